// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch/decode/exec/mem/write
// using enable/done handshakes and owns the architectural PC and retired-instruction counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        fetch_enable,
  input  logic        fetch_done,
  output logic [31:0] pc,
  output logic        decode_enable,
  input  logic        decode_done,
  input  logic        dec_mem,
  input  logic        dec_wb,
  input  logic        dec_halt,
  output logic        exec_enable,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_enable,
  input  logic        mem_done,
  output logic        write_enable,
  input  logic        write_done,
  output logic        busy,
  output logic        halted,
  output logic [31:0] inst_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WRITE, HALT} state_t;

  state_t      state, state_next;
  // entry marks the first cycle in a state: it drives the strobe and masks a same-cycle done
  logic        entry;
  logic        mem_q, wb_q, br_q;
  logic [31:0] tgt_q;
  logic        retire;
  logic        taken;
  logic [31:0] tgt_sel, next_pc;

  // A retire straight out of EXEC must see the live branch result, not the stale latch
  assign taken   = (state == EXEC) ? branch_taken  : br_q;
  assign tgt_sel = (state == EXEC) ? branch_target : tgt_q;
  assign next_pc = taken ? (tgt_sel & 32'hFFFF_FFFC) : pc + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      entry      <= 1'b0;
      pc         <= RESET_PC;
      inst_count <= 32'd0;
      mem_q      <= 1'b0;
      wb_q       <= 1'b0;
      br_q       <= 1'b0;
      tgt_q      <= 32'd0;
    end else begin
      state <= state_next;
      entry <= (state_next != state);
      if (state == DECODE && decode_done && !entry) begin
        mem_q <= dec_mem;
        wb_q  <= dec_wb;
      end
      if (state == EXEC && exec_done && !entry) begin
        br_q  <= branch_taken;
        tgt_q <= branch_target;
      end
      if (retire) begin
        pc         <= next_pc;
        inst_count <= inst_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH:  if (fetch_done && !entry) state_next = DECODE;
      DECODE: if (decode_done && !entry) state_next = dec_halt ? HALT : EXEC;
      EXEC: begin
        if (exec_done && !entry) begin
          if (mem_q)     state_next = MEM;
          else if (wb_q) state_next = WRITE;
          else begin
            state_next = FETCH;
            retire     = 1'b1;
          end
        end
      end
      MEM: begin
        if (mem_done && !entry) begin
          if (wb_q) state_next = WRITE;
          else begin
            state_next = FETCH;
            retire     = 1'b1;
          end
        end
      end
      WRITE: begin
        if (write_done && !entry) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      default: state_next = state;
    endcase
  end

  always_comb begin
    fetch_enable  = 1'b0;
    decode_enable = 1'b0;
    exec_enable   = 1'b0;
    mem_enable    = 1'b0;
    write_enable  = 1'b0;
    busy          = 1'b1;
    halted        = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      FETCH:   fetch_enable  = entry;
      DECODE:  decode_enable = entry;
      EXEC:    exec_enable   = entry;
      MEM:     mem_enable    = entry;
      WRITE:   write_enable  = entry;
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the core. It steps each instruction through the fetch, decode, exec, mem and write units using per-stage enable/done handshakes. It owns the architectural PC and the retired-instruction counter. It sits above the decode unit and its sibling stage units and is the only source of their enable strobes.

## Interface
Parameters:
- RESET_PC, 32'h0, PC value after reset.
- PC_STEP, 32'd4, sequential PC increment.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high; one clock, reset asynchronous and active-high.
- start  in  1  begin execution; sampled only in IDLE.
- fetch_enable  out  1  one-cycle strobe to the fetch unit.
- fetch_done  in  1  fetch complete.
- pc  out  32  current PC, presented to fetch.
- decode_enable  out  1  one-cycle strobe to decode.
- decode_done  in  1  decode complete; dec_* flags are valid this cycle.
- dec_mem  in  1  instruction needs the mem stage.
- dec_wb  in  1  instruction needs the write stage.
- dec_halt  in  1  instruction is halt.
- exec_enable  out  1  one-cycle strobe to exec.
- exec_done  in  1  exec complete; branch_* are valid this cycle.
- branch_taken  in  1  redirect the PC.
- branch_target  in  32  redirect address.
- mem_enable  out  1  one-cycle strobe to mem.
- mem_done  in  1  mem complete.
- write_enable  out  1  one-cycle strobe to register write-back.
- write_done  in  1  write-back complete.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- inst_count  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WRITE, HALT.
- IDLE --start--> FETCH.
- FETCH --fetch_done--> DECODE.
- DECODE --decode_done--> HALT if dec_halt, otherwise EXEC.
- EXEC --exec_done--> MEM if dec_mem; else WRITE if dec_wb; else retire, then FETCH.
- MEM --mem_done--> WRITE if dec_wb; else retire, then FETCH.
- WRITE --write_done--> retire, then FETCH.
- HALT is terminal; only rst leaves it.
- dec_mem, dec_wb and dec_halt are latched internally at decode_done. Later changes on those inputs are ignored.
- branch_taken and branch_target are latched at exec_done.
- Next PC:
  - taken branch: {branch_target[31:2], 2'b00};
  - otherwise: pc + PC_STEP, modulo 2^32.
- Retire:
  - pc loads the next PC;
  - inst_count increments by 1, wrapping 32'hFFFFFFFF -> 0.
- Halt instruction: does not retire. pc and inst_count are unchanged, and exec, mem and write are never strobed.
- A done input arriving outside its stage's state is ignored. This includes a done in the same cycle as its own enable.
- start outside IDLE is ignored.
- Simultaneous done on several inputs: only the done matching the current state acts.

## Timing
- Reset values (applied asynchronously on rst):
  - all *_enable = 0, busy = 0, halted = 0;
  - pc = RESET_PC, inst_count = 0;
  - state = IDLE.
- rst mid-instruction:
  - an in-flight stage is abandoned and nothing retires;
  - a done arriving after reset release is ignored, because the FSM is in IDLE.
- start sampled high at edge t: fetch_enable is high for cycle t+1 only.
- Stage done sampled at edge t:
  - the next stage's enable is high for cycle t+1;
  - on retire, pc and inst_count update at edge t, and fetch_enable is high in cycle t+1 with the new pc.
- Each enable is high exactly one cycle per entry into its state.
- Minimum instruction latency with 1-cycle units, all stages used: 10 cycles, start to the next fetch_enable.
- pc is stable from the fetch_enable cycle until retire.

## Test plan
- Reset then start, all units answer done one cycle after enable, dec_mem=dec_wb=1, no branch:
  - strobe order fetch, decode, exec, mem, write;
  - pc 0 -> 4, inst_count 0 -> 1;
  - fetch_enable is seen again.
- dec_mem=0, dec_wb=1: mem_enable never asserts and write_enable follows exec_done by 1 cycle. dec_mem=dec_wb=0: retire at exec_done.
- branch_taken=1 with branch_target=32'h1003:
  - pc becomes 32'h1000;
  - then one sequential instruction gives pc 32'h1004.
- dec_halt=1 at decode_done:
  - halted=1, busy=0, no exec_enable;
  - pc and inst_count unchanged;
  - later start pulses and spurious dones cause no strobes.
- Spurious dones: exec_done during FETCH, and fetch_done in the same cycle as fetch_enable. Both are ignored; the FSM waits for the proper done. Also preload inst_count = 32'hFFFFFFFF via 2^32-1 retires, or force it; one retire wraps it to 0.
- Assert rst while in MEM:
  - all outputs return to reset values immediately, without waiting for a clock;
  - a mem_done after release does nothing;
  - a new start fetches from RESET_PC.
